// File: rtl/mmio_ctrl_pkg.sv
// mmio_ctrl_pkg: MMIO address map, magic values and address decode helper.
package mmio_ctrl_pkg;
    localparam int XLEN = 32;
    localparam logic [3:0] DMEM_NIBBLE = 4'h0;
    localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
    localparam logic [31:0] CONSOLE_STAT_ADDR = 32'h1000_0004;
    localparam logic [31:0] TEST_STAT_ADDR = 32'h2000_0000;
    localparam logic [31:0] TEST_PASS_MAGIC = 32'd123456789;

    typedef enum logic [2:0] {
        SEL_DMEM,
        SEL_CONSOLE,
        SEL_CSTAT,
        SEL_TEST,
        SEL_UNMAPPED
    } sel_e;

    function automatic sel_e decode(input logic [31:0] addr);
        return addr[31:28] == DMEM_NIBBLE ? SEL_DMEM :
               addr == CONSOLE_ADDR ? SEL_CONSOLE :
               addr == CONSOLE_STAT_ADDR ? SEL_CSTAT :
               addr == TEST_STAT_ADDR ? SEL_TEST : SEL_UNMAPPED;
    endfunction
endpackage

// File: rtl/mmio_ctrl_console_fifo.sv
// console_fifo: circular FIFO with wrap-around pointers and an occupancy count.
module console_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_full,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: routes data accesses to dmem, the console FIFO or the sticky test-status flags.
module mmio_ctrl
    import mmio_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] core_addr,
    input  logic [XLEN-1:0] core_wdata,
    input  logic            core_we,
    output logic [XLEN-1:0] core_rdata,
    output logic            stall,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic            dmem_we,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            console_valid,
    output logic [XLEN-1:0] console_data,
    input  logic            console_ready,
    output logic            test_passed,
    output logic            test_failed,
    output logic            mmio_error
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    sel_e          w_sel;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_con_we;
    logic          r_passed;
    logic          r_failed;
    logic          r_error;

    assign w_sel      = decode(core_addr);
    assign w_con_we   = core_we && w_sel == SEL_CONSOLE && !reset;
    assign stall      = w_con_we && w_full;
    assign dmem_addr  = core_addr;
    assign dmem_wdata = core_wdata;
    assign dmem_we    = core_we && w_sel == SEL_DMEM && !reset;

    assign console_valid = !w_empty;
    assign test_passed   = r_passed;
    assign test_failed   = r_failed;
    assign mmio_error    = r_error;

    assign core_rdata = w_sel == SEL_DMEM ? dmem_rdata :
                        w_sel == SEL_CSTAT ? XLEN'({w_full, w_empty, w_count}) :
                        w_sel == SEL_TEST ? XLEN'({r_failed, r_passed}) : '0;

    console_fifo #(
        .WIDTH(XLEN),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_con_we && !w_full),
        .i_data  (core_wdata),
        .o_full  (w_full),
        .i_pop   (console_valid && console_ready),
        .o_head  (console_data),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Stores to the read-only status word count as unmapped stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_passed <= 1'b0;
            r_failed <= 1'b0;
            r_error  <= 1'b0;
        end else if (core_we) begin
            if (w_sel == SEL_TEST && core_wdata == TEST_PASS_MAGIC) r_passed <= 1'b1;
            if (w_sel == SEL_TEST && core_wdata != TEST_PASS_MAGIC) r_failed <= 1'b1;
            if (w_sel == SEL_CSTAT || w_sel == SEL_UNMAPPED) r_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mmio_ctrl.sv
// tb_mmio_ctrl: directed vectors against mmio_ctrl with a small dmem model.
module tb_mmio_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_we;
    logic [31:0] core_rdata;
    logic        stall;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;
    logic        console_valid;
    logic [31:0] console_data;
    logic        console_ready;
    logic        test_passed;
    logic        test_failed;
    logic        mmio_error;
    logic [31:0] mem [64];
    int          checks = 0;
    int          failures = 0;

    mmio_ctrl #(.FIFO_DEPTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_we       (core_we),
        .core_rdata    (core_rdata),
        .stall         (stall),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_we       (dmem_we),
        .dmem_rdata    (dmem_rdata),
        .console_valid (console_valid),
        .console_data  (console_data),
        .console_ready (console_ready),
        .test_passed   (test_passed),
        .test_failed   (test_failed),
        .mmio_error    (mmio_error)
    );

    always #5 clk = ~clk;

    assign dmem_rdata = mem[dmem_addr[7:2]];
    always @(posedge clk) if (dmem_we) mem[dmem_addr[7:2]] <= dmem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
        core_we = we;
        core_addr = addr;
        core_wdata = data;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        reset = 1'b1;
        console_ready = 1'b0;
        drive(1'b1, 32'h1000_0000, 32'h77);
        chk("stall_in_reset", {31'b0, stall}, 32'd0);
        drive(1'b1, 32'h0000_0100, 32'h77);
        chk("dmem_we_in_reset", {31'b0, dmem_we}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        drive(1'b0, 32'h1000_0004, 32'h0);
        chk("rst_valid", {31'b0, console_valid}, 32'd0);
        chk("rst_flags", {29'b0, mmio_error, test_failed, test_passed}, 32'd0);
        chk("rst_cstat", core_rdata, 32'h10);

        drive(1'b1, 32'h0000_0100, 32'hAB);
        chk("dmem_we_store", {31'b0, dmem_we}, 32'd1);
        chk("dmem_wdata", dmem_wdata, 32'hAB);
        tick();
        drive(1'b0, 32'h0000_0100, 32'h0);
        chk("dmem_we_pulse", {31'b0, dmem_we}, 32'd0);
        chk("dmem_load", core_rdata, 32'hAB);
        chk("dmem_no_push", {31'b0, console_valid}, 32'd0);
        chk("dmem_no_flags", {29'b0, mmio_error, test_failed, test_passed}, 32'd0);

        console_ready = 1'b1;
        drive(1'b1, 32'h1000_0000, 32'h48);
        chk("hi_stall0", {31'b0, stall}, 32'd0);
        chk("hi_no_bypass", {31'b0, console_valid}, 32'd0);
        tick();
        drive(1'b1, 32'h1000_0000, 32'h69);
        chk("hi_valid_h", {31'b0, console_valid}, 32'd1);
        chk("hi_data_h", console_data, 32'h48);
        chk("hi_stall1", {31'b0, stall}, 32'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("hi_valid_i", {31'b0, console_valid}, 32'd1);
        chk("hi_data_i", console_data, 32'h69);
        tick();
        chk("hi_drained", {31'b0, console_valid}, 32'd0);

        console_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h1000_0000, 32'h100 + i);
            chk("fill_stall", {31'b0, stall}, 32'd0);
            tick();
        end
        drive(1'b0, 32'h1000_0004, 32'h0);
        chk("full_cstat", core_rdata, 32'h28);
        drive(1'b1, 32'h1000_0000, 32'h200);
        chk("full_stall", {31'b0, stall}, 32'd1);
        chk("full_no_dmem", {31'b0, dmem_we}, 32'd0);
        tick();
        chk("full_stall_held", {31'b0, stall}, 32'd1);
        chk("full_head_stable", console_data, 32'h100);
        console_ready = 1'b1;
        #1;
        chk("pop_full_stall", {31'b0, stall}, 32'd1);
        tick();
        console_ready = 1'b0;
        #1;
        chk("retry_stall_drop", {31'b0, stall}, 32'd0);
        chk("retry_head", console_data, 32'h101);
        tick();
        drive(1'b0, 32'h1000_0004, 32'h0);
        chk("refull_cstat", core_rdata, 32'h28);
        console_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", {31'b0, console_valid}, 32'd1);
            chk("drain_data", console_data, i < 7 ? 32'h101 + i : 32'h200);
            tick();
        end
        chk("drain_empty", {31'b0, console_valid}, 32'd0);
        chk("drain_cstat", core_rdata, 32'h10);
        console_ready = 1'b0;

        drive(1'b1, 32'h2000_0000, 32'd123456789);
        tick();
        drive(1'b0, 32'h2000_0000, 32'h0);
        chk("pass_flag", {30'b0, test_failed, test_passed}, 32'h1);
        chk("pass_load", core_rdata, 32'h1);
        drive(1'b1, 32'h2000_0000, 32'd5);
        tick();
        drive(1'b0, 32'h2000_0000, 32'h0);
        chk("fail_flag", {30'b0, test_failed, test_passed}, 32'h3);
        chk("fail_load", core_rdata, 32'h3);
        chk("test_no_err", {31'b0, mmio_error}, 32'd0);

        drive(1'b1, 32'h1000_0000, 32'h55);
        tick();
        drive(1'b1, 32'h3000_0000, 32'hDEAD);
        chk("unmapped_dmem_we", {31'b0, dmem_we}, 32'd0);
        chk("unmapped_no_err_yet", {31'b0, mmio_error}, 32'd0);
        tick();
        drive(1'b0, 32'h3000_0100, 32'h0);
        chk("unmapped_err", {31'b0, mmio_error}, 32'd1);
        chk("unmapped_load", core_rdata, 32'h0);
        chk("dmem_untouched", mem[0], 32'hAB);
        chk("pre_reset_valid", {31'b0, console_valid}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 32'h1000_0004, 32'h0);
        chk("post_rst_flags", {29'b0, mmio_error, test_failed, test_passed}, 32'd0);
        chk("post_rst_valid", {31'b0, console_valid}, 32'd0);
        chk("post_rst_cstat", core_rdata, 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_ctrl.md
# mmio_ctrl

Memory-mapped I/O controller between the datapath's data-memory port and `dmem`. It decodes every data access and routes it to `dmem`, a buffered console output channel, or the sticky test-status register. Console stores drain through a FIFO with a valid/ready handshake. When that FIFO is full, the controller stalls the datapath. It also flags stores to unmapped MMIO addresses.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: console FIFO entries; power of two, ≥2.
- `XLEN`, from `constants.vh`: data/address width (32).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `core_addr` in XLEN: datapath data address.
- `core_wdata` in XLEN: datapath store data.
- `core_we` in 1: datapath store strobe.
- `core_rdata` out XLEN: load data returned to the datapath.
- `stall` out 1: datapath must hold PC and all architectural state while this is high.
- `dmem_addr` out XLEN: equals `core_addr`.
- `dmem_wdata` out XLEN: store data to `dmem`.
- `dmem_we` out 1: store strobe to `dmem`.
- `dmem_rdata` in XLEN: `dmem` read data.
- `console_valid` out 1: FIFO head valid.
- `console_data` out XLEN: FIFO head word.
- `console_ready` in 1: consumer accepts head.
- `test_passed` out 1: sticky pass flag.
- `test_failed` out 1: sticky fail flag.
- `mmio_error` out 1: sticky unmapped-MMIO store flag.

## Operation
- MMIO window is `core_addr[31:28] != 0`. All other addresses go to `dmem`.
- Address decode:
  - `CONSOLE_ADDR` (0x1000_0000): console data (write-only).
  - `CONSOLE_STAT_ADDR` (0x1000_0004): read-only status.
  - `TEST_STAT_ADDR` (0x2000_0000): test status.
- `dmem` path: `dmem_we = core_we && !mmio && !reset` and `dmem_wdata = core_wdata`. MMIO stores never reach `dmem`.
- Console store:
  - Not full: push `core_wdata`; `stall` = 0.
  - Full: `stall` = 1 and no push. The datapath holds the store, and it retries every cycle until space frees up.
- Test-status store:
  - `core_wdata == TEST_PASS_MAGIC` (123456789) sets `test_passed`.
  - Any other value sets `test_failed`.
  - Both flags are sticky until reset and can both end up set.
- Store to any other MMIO address sets `mmio_error` (sticky). The store is otherwise dropped.
- Loads (combinational):
  - Non-MMIO: `dmem_rdata`.
  - `CONSOLE_STAT_ADDR`: `{full, empty, count}`, zero-extended; count is $clog2(FIFO_DEPTH)+1 bits, placed at bit 0.
  - `TEST_STAT_ADDR`: `{30'b0, test_failed, test_passed}`.
  - Other MMIO addresses: 0.
- FIFO:
  - Pop when `console_valid && console_ready`.
  - `console_valid = !empty`.
  - `console_data` = head word; it is held stable while valid and not popped.
- Reset values: FIFO empty (count 0, pointers 0), `console_valid` 0, `test_passed`/`test_failed`/`mmio_error` 0. `stall` and `dmem_we` are forced 0 while `reset` is high.

## Timing
- `dmem`, status and flag writes take effect at the clock edge where `core_we` is high.
- A pushed word appears on `console_data` with `console_valid` = 1 in the next cycle.
- `stall` is combinational: `core_we && addr==CONSOLE_ADDR && full`, using the registered `full`.
- Pop on a full FIFO: `stall` is still asserted that cycle. The held store pushes on the following cycle, giving exactly one bubble.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- Push into an empty FIFO with `console_ready` high: no same-cycle bypass; the word pops one cycle later at the earliest.
- Pointers wrap modulo `FIFO_DEPTH`. Count saturates at neither end by construction: push is blocked when full, pop is blocked when empty.
- Reset mid-drain: all queued words are discarded. `console_valid` drops in the cycle after the reset edge.

## Structure
- Add to `constants.vh`: `CONSOLE_ADDR`, `CONSOLE_STAT_ADDR`, `TEST_STAT_ADDR`, `TEST_PASS_MAGIC`, and the MMIO window nibble.
- One sub-module `console_fifo`:
  - Parameters `WIDTH`, `DEPTH`.
  - Ports: push/data/full, pop/head/empty, count.
  - Register array, wrap-around pointers, synchronous reset.
- `mmio_ctrl` holds the decode logic, the sticky flags and the read mux.

## Test plan
- Store 0xAB to 0x0000_0100, then load 0x0000_0100 -> `dmem_we` pulses 1 cycle and the load returns 0xAB. No FIFO push, no flag change.
- Store 'H','i' to 0x1000_0000 with `console_ready`=1 -> `console_data` shows 0x48 then 0x69 on consecutive cycles, starting 1 cycle after the first store; `stall` never asserts.
- `console_ready`=0; store 9 words with `FIFO_DEPTH`=8:
  - 9th store -> `stall`=1 and status load returns full=1, count=8.
  - Raise `console_ready` for 1 cycle -> 9th word pushes on the next cycle and `stall` drops.
  - Order is preserved on drain.
- Store 123456789 to 0x2000_0000 -> `test_passed`=1 next cycle and load returns 0x1. A later store of 5 -> `test_failed`=1 and load returns 0x3.
- Store to 0x3000_0000 -> `mmio_error`=1 with `dmem_we`=0. Assert `reset` for 1 cycle -> all flags 0, FIFO empty, `console_valid`=0.
